// File: rtl/nd_1to2_pkg.sv
// Shared constants, the output handshake state type and small helpers
// for the 1-to-2 address-routing splitter.
package nd_1to2_pkg;

    localparam int unsigned NS_1TO2_FSZ     = 2;
    localparam int unsigned NS_ADDRESS_SIZE = 6;
    localparam int unsigned NS_DATA_SIZE    = 8;
    localparam int unsigned NS_REDUN_SIZE   = 4;
    localparam int unsigned NS_1TO2_SPLIT   = 4;

    typedef enum logic [1:0] {
        SND_IDLE = 2'd0,
        SND_REQ  = 2'd1,
        SND_WAIT = 2'd2
    } snd_state_e;

    function automatic int unsigned msg_width(input int unsigned asz,
                                              input int unsigned dsz,
                                              input int unsigned rsz);
        return 2 * asz + dsz + rsz;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned fsz);
        return 32'd1 << fsz;
    endfunction

    // Unsigned threshold compare; widened to 32 bits so SPLIT may equal 2^ASZ.
    function automatic logic dst_to_snd1(input logic [31:0] dst,
                                         input logic [31:0] split);
        return dst >= split;
    endfunction

endpackage

// File: rtl/nd_1to2_fifo.sv
// Per-output message FIFO: 2^FSZ entries, registered count, synchronous clear.
// A push is refused whenever the FIFO is full at the start of the cycle.
module nd_msg_fifo
    import nd_1to2_pkg::*;
#(
    parameter int unsigned FSZ = NS_1TO2_FSZ,
    parameter int unsigned ASZ = NS_ADDRESS_SIZE,
    parameter int unsigned DSZ = NS_DATA_SIZE,
    parameter int unsigned RSZ = NS_REDUN_SIZE
) (
    input  logic                       i_clk,
    input  logic                       clr,
    input  logic                       push,
    input  logic [2*ASZ+DSZ+RSZ-1:0]   wr_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [2*ASZ+DSZ+RSZ-1:0]   rd_data,
    output logic [FSZ:0]               count
);

    localparam int unsigned MW    = msg_width(ASZ, DSZ, RSZ);
    localparam int unsigned DEPTH = fifo_depth(FSZ);

    logic [MW-1:0]  mem_q [DEPTH];
    logic [FSZ-1:0] head_q, head_d;
    logic [FSZ-1:0] tail_q, tail_d;
    logic [FSZ:0]   count_q, count_d;
    logic           do_push, do_pop;

    assign full    = (count_q == (FSZ+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[tail_q];
    assign count   = count_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        do_push = push && !full && !clr;
        do_pop  = pop && !empty && !clr;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) head_d = head_q + 1'b1;
            if (do_pop)  tail_d = tail_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    // NOTE: storage is not reset; count/pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[head_q] <= wr_data;
    end

endmodule

// File: rtl/nd_1to2.sv
// Address-routing splitter: one req/ack input channel steered by dst to two
// req/ack outputs, each buffered by its own FIFO so one stalled consumer
// never blocks the other.
module nd_1to2
    import nd_1to2_pkg::*;
#(
    parameter int unsigned FSZ   = NS_1TO2_FSZ,
    parameter int unsigned ASZ   = NS_ADDRESS_SIZE,
    parameter int unsigned DSZ   = NS_DATA_SIZE,
    parameter int unsigned RSZ   = NS_REDUN_SIZE,
    parameter int unsigned SPLIT = NS_1TO2_SPLIT
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,

    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv0_req,
    output logic           rcv0_ack,

    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req,
    input  logic           snd0_ack,

    output logic [ASZ-1:0] snd1_src,
    output logic [ASZ-1:0] snd1_dst,
    output logic [DSZ-1:0] snd1_dat,
    output logic [RSZ-1:0] snd1_red,
    output logic           snd1_req,
    input  logic           snd1_ack
);

    localparam int unsigned MW = msg_width(ASZ, DSZ, RSZ);

    logic                  ready_q, ready_d;
    logic                  rcv_ack_q, rcv_ack_d;
    logic                  clear;
    logic                  to_snd1;
    logic [MW-1:0]         wr_data;

    snd_state_e            snd_state_q [2];
    snd_state_e            snd_state_d [2];
    logic [1:0]            snd_req_q, snd_req_d;
    logic [1:0][MW-1:0]    snd_msg_q, snd_msg_d;
    logic [1:0]            snd_ack;

    logic [1:0]            push, pop, full, empty;
    logic [1:0][MW-1:0]    fifo_rd;
    logic [1:0][FSZ:0]     fifo_count_unused;

    // Reset and the one-cycle init step both wipe all state.
    assign clear   = reset || !ready_q;
    assign wr_data = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    assign snd_ack = {snd1_ack, snd0_ack};
    assign to_snd1 = dst_to_snd1(32'(rcv0_dst), 32'(SPLIT));

    for (genvar k = 0; k < 2; k++) begin : g_fifo
        nd_msg_fifo #(
            .FSZ (FSZ),
            .ASZ (ASZ),
            .DSZ (DSZ),
            .RSZ (RSZ)
        ) u_fifo (
            .i_clk   (i_clk),
            .clr     (clear),
            .push    (push[k]),
            .wr_data (wr_data),
            .pop     (pop[k]),
            .full    (full[k]),
            .empty   (empty[k]),
            .rd_data (fifo_rd[k]),
            .count   (fifo_count_unused[k])
        );
    end

    always_comb begin
        ready_d     = ready_q;
        rcv_ack_d   = rcv_ack_q;
        push        = '0;
        pop         = '0;
        snd_state_d = snd_state_q;
        snd_req_d   = snd_req_q;
        snd_msg_d   = snd_msg_q;

        if (clear) begin
            ready_d   = !reset;
            rcv_ack_d = 1'b0;
            snd_req_d = '0;
            snd_msg_d = '0;
            for (int k = 0; k < 2; k++) snd_state_d[k] = SND_IDLE;
        end else begin
            // A full target stalls the input even if the other FIFO has room.
            if (rcv0_req && !rcv_ack_q) begin
                if (!full[to_snd1]) begin
                    push[to_snd1] = 1'b1;
                    rcv_ack_d     = 1'b1;
                end
            end else if (!rcv0_req && rcv_ack_q) begin
                rcv_ack_d = 1'b0;
            end

            for (int k = 0; k < 2; k++) begin
                case (snd_state_q[k])
                    SND_IDLE: begin
                        if (!empty[k]) begin
                            snd_msg_d[k]   = fifo_rd[k];
                            pop[k]         = 1'b1;
                            snd_req_d[k]   = 1'b1;
                            snd_state_d[k] = SND_REQ;
                        end
                    end
                    SND_REQ: begin
                        if (snd_ack[k]) begin
                            snd_req_d[k]   = 1'b0;
                            snd_state_d[k] = SND_WAIT;
                        end
                    end
                    SND_WAIT: begin
                        if (!snd_ack[k]) snd_state_d[k] = SND_IDLE;
                    end
                    default: begin
                        snd_req_d[k]   = 1'b0;
                        snd_state_d[k] = SND_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            ready_q   <= 1'b0;
            rcv_ack_q <= 1'b0;
            snd_req_q <= '0;
            snd_msg_q <= '0;
            for (int k = 0; k < 2; k++) snd_state_q[k] <= SND_IDLE;
        end else begin
            ready_q     <= ready_d;
            rcv_ack_q   <= rcv_ack_d;
            snd_req_q   <= snd_req_d;
            snd_msg_q   <= snd_msg_d;
            snd_state_q <= snd_state_d;
        end
    end

    assign ready    = ready_q;
    assign rcv0_ack = rcv_ack_q;
    assign snd0_req = snd_req_q[0];
    assign snd1_req = snd_req_q[1];
    assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = snd_msg_q[0];
    assign {snd1_src, snd1_dst, snd1_dat, snd1_red} = snd_msg_q[1];

endmodule

// File: tb/tb_nd_1to2.sv
// Scoreboard bench for nd_1to2: expected messages are queued per output when
// the input accepts them and compared in order by the two consumer processes.
module tb_nd_1to2;

    localparam int unsigned FSZ    = 2;
    localparam int unsigned ASZ    = 6;
    localparam int unsigned DSZ    = 8;
    localparam int unsigned RSZ    = 4;
    localparam int unsigned SPLIT  = 4;
    localparam int          BUDGET = 60;

    typedef struct packed {
        logic [ASZ-1:0] src;
        logic [ASZ-1:0] dst;
        logic [DSZ-1:0] dat;
        logic [RSZ-1:0] red;
    } msg_t;

    logic           i_clk;
    logic           reset;
    logic           ready;
    logic [ASZ-1:0] rcv0_src, rcv0_dst;
    logic [DSZ-1:0] rcv0_dat;
    logic [RSZ-1:0] rcv0_red;
    logic           rcv0_req, rcv0_ack;
    logic [ASZ-1:0] snd0_src, snd0_dst, snd1_src, snd1_dst;
    logic [DSZ-1:0] snd0_dat, snd1_dat;
    logic [RSZ-1:0] snd0_red, snd1_red;
    logic           snd0_req, snd0_ack, snd1_req, snd1_ack;

    msg_t exp0[$];
    msg_t exp1[$];
    int   checks = 0;
    int   errors = 0;
    int   dlv0 = 0;
    int   dlv1 = 0;
    bit   cons_en0 = 0;
    bit   cons_en1 = 0;
    bit   cons_rand1 = 0;

    nd_1to2 #(
        .FSZ   (FSZ),
        .ASZ   (ASZ),
        .DSZ   (DSZ),
        .RSZ   (RSZ),
        .SPLIT (SPLIT)
    ) dut (
        .i_clk    (i_clk),
        .reset    (reset),
        .ready    (ready),
        .rcv0_src (rcv0_src),
        .rcv0_dst (rcv0_dst),
        .rcv0_dat (rcv0_dat),
        .rcv0_red (rcv0_red),
        .rcv0_req (rcv0_req),
        .rcv0_ack (rcv0_ack),
        .snd0_src (snd0_src),
        .snd0_dst (snd0_dst),
        .snd0_dat (snd0_dat),
        .snd0_red (snd0_red),
        .snd0_req (snd0_req),
        .snd0_ack (snd0_ack),
        .snd1_src (snd1_src),
        .snd1_dst (snd1_dst),
        .snd1_dat (snd1_dat),
        .snd1_red (snd1_red),
        .snd1_req (snd1_req),
        .snd1_ack (snd1_ack)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Consumer for snd0: acks each request after comparing it to the scoreboard.
    initial begin
        msg_t got;
        snd0_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (reset) begin
                snd0_ack = 1'b0;
            end else if (cons_en0) begin
                if (snd0_req && !snd0_ack) begin
                    got = {snd0_src, snd0_dst, snd0_dat, snd0_red};
                    checks++;
                    if (exp0.size() == 0) begin
                        errors++;
                        $display("FAIL snd0_unexpected: got %h, expected no message", got);
                    end else begin
                        if (got !== exp0[0]) begin
                            errors++;
                            $display("FAIL snd0_data: got %h expected %h", got, exp0[0]);
                        end
                        void'(exp0.pop_front());
                    end
                    dlv0++;
                    snd0_ack = 1'b1;
                end else if (!snd0_req && snd0_ack) begin
                    snd0_ack = 1'b0;
                end
            end
        end
    end

    // Consumer for snd1, optionally inserting a random delay before each ack.
    initial begin
        msg_t got;
        int   hold = 0;
        snd1_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (reset) begin
                snd1_ack = 1'b0;
                hold = 0;
            end else if (cons_en1) begin
                if (snd1_req && !snd1_ack) begin
                    if (hold > 0) begin
                        hold--;
                    end else begin
                        got = {snd1_src, snd1_dst, snd1_dat, snd1_red};
                        checks++;
                        if (exp1.size() == 0) begin
                            errors++;
                            $display("FAIL snd1_unexpected: got %h, expected no message", got);
                        end else begin
                            if (got !== exp1[0]) begin
                                errors++;
                                $display("FAIL snd1_data: got %h expected %h", got, exp1[0]);
                            end
                            void'(exp1.pop_front());
                        end
                        dlv1++;
                        snd1_ack = 1'b1;
                        hold = cons_rand1 ? int'($urandom_range(0, 3)) : 0;
                    end
                end else if (!snd1_req && snd1_ack) begin
                    snd1_ack = 1'b0;
                end
            end
        end
    end

    function automatic msg_t mk(input int src, input int dst, input int dat, input int red);
        msg_t m;
        m.src = ASZ'(src);
        m.dst = ASZ'(dst);
        m.dat = DSZ'(dat);
        m.red = RSZ'(red);
        return m;
    endfunction

    task automatic drive_msg(input msg_t m);
        rcv0_src = m.src;
        rcv0_dst = m.dst;
        rcv0_dat = m.dat;
        rcv0_red = m.red;
        rcv0_req = 1'b1;
    endtask

    task automatic send_msg(input msg_t m, input string tag);
        int n = 0;
        @(negedge i_clk);
        drive_msg(m);
        do begin
            @(negedge i_clk);
            n++;
        end while (!rcv0_ack && n < BUDGET);
        checks++;
        if (rcv0_ack !== 1'b1) begin
            errors++;
            $display("FAIL %s: rcv0_ack=%b, expected 1 within %0d cycles", tag, rcv0_ack, BUDGET);
        end else if (m.dst < ASZ'(SPLIT)) begin
            exp0.push_back(m);
        end else begin
            exp1.push_back(m);
        end
        rcv0_req = 1'b0;
        n = 0;
        while (rcv0_ack && n < BUDGET) begin
            @(negedge i_clk);
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0 || snd0_req || snd1_req ||
                snd0_ack || snd1_ack || rcv0_ack) && n < 4 * BUDGET) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0 || snd0_req || snd1_req) begin
            errors++;
            $display("FAIL %s: pending snd0=%0d snd1=%0d, expected all delivered",
                     tag, exp0.size(), exp1.size());
        end
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({ready, rcv0_ack, snd0_req, snd1_req} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: ready/ack/req0/req1=%b expected 0000",
                     {ready, rcv0_ack, snd0_req, snd1_req});
        end
        checks++;
        if ({snd0_src, snd0_dst, snd0_dat, snd0_red} !== '0) begin
            errors++;
            $display("FAIL reset_msg0: got %h expected 0", {snd0_src, snd0_dst, snd0_dat, snd0_red});
        end
        reset = 1'b0;
        @(negedge i_clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%b expected 1 one cycle after release", ready);
        end
    endtask

    task automatic test_single_route;
        msg_t m;
        cons_en0 = 0;
        cons_en1 = 0;
        m = mk(9, 2, 8'h5A, 3);
        @(negedge i_clk);
        drive_msg(m);
        exp0.push_back(m);
        @(negedge i_clk);
        checks++;
        if (rcv0_ack !== 1'b1 || snd0_req !== 1'b0) begin
            errors++;
            $display("FAIL route0_first_edge: ack=%b req0=%b expected ack=1 req0=0", rcv0_ack, snd0_req);
        end
        rcv0_req = 1'b0;
        @(negedge i_clk);
        checks++;
        if (snd0_req !== 1'b1 || snd0_dst !== 6'd2 || snd0_dat !== 8'h5A || snd1_req !== 1'b0) begin
            errors++;
            $display("FAIL route0_out: req0=%b dst=%0d dat=%h req1=%b expected 1 2 5a 0",
                     snd0_req, snd0_dst, snd0_dat, snd1_req);
        end
        cons_en0 = 1;
        wait_idle("route0_drain");

        m = mk(1, 4, 8'hA5, 5);
        @(negedge i_clk);
        drive_msg(m);
        exp1.push_back(m);
        @(negedge i_clk);
        rcv0_req = 1'b0;
        @(negedge i_clk);
        checks++;
        if (snd1_req !== 1'b1 || snd1_dst !== 6'd4 || snd1_dat !== 8'hA5 || snd0_req !== 1'b0) begin
            errors++;
            $display("FAIL route1_out: req1=%b dst=%0d dat=%h req0=%b expected 1 4 a5 0",
                     snd1_req, snd1_dst, snd1_dat, snd0_req);
        end
        cons_en1 = 1;
        wait_idle("route1_drain");
    endtask

    task automatic test_isolation;
        int  base1;
        int  n;
        bit  early_ack = 0;
        cons_en0 = 0;
        cons_en1 = 1;
        // One message sits in the snd0 register, four more fill fifo0.
        for (int i = 0; i < 5; i++) send_msg(mk(2, 1, 8'h30 + i, i), "iso_fill_ack");
        checks++;
        if (snd0_req !== 1'b1) begin
            errors++;
            $display("FAIL iso_req0: req0=%b expected 1 while stalled", snd0_req);
        end
        base1 = dlv1;
        send_msg(mk(3, 7, 8'h77, 7), "iso_other_ack");
        n = 0;
        while ((exp1.size() != 0 || snd1_req) && n < BUDGET) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (dlv1 != base1 + 1 || exp1.size() != 0) begin
            errors++;
            $display("FAIL iso_other_delivered: delivered=%0d expected %0d", dlv1 - base1, 1);
        end
        @(negedge i_clk);
        drive_msg(mk(4, 1, 8'h99, 9));
        repeat (8) begin
            @(negedge i_clk);
            if (rcv0_ack) early_ack = 1;
        end
        checks++;
        if (early_ack) begin
            errors++;
            $display("FAIL iso_blocked: ack seen=%b expected 0 while fifo0 full", early_ack);
        end
        cons_en0 = 1;
        n = 0;
        while (!rcv0_ack && n < BUDGET) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (rcv0_ack !== 1'b1) begin
            errors++;
            $display("FAIL iso_unblock: ack=%b expected 1 after snd0 handshake", rcv0_ack);
        end else begin
            exp0.push_back(mk(4, 1, 8'h99, 9));
        end
        rcv0_req = 1'b0;
        wait_idle("iso_drain");
    endtask

    task automatic test_wrap;
        int base1 = dlv1;
        cons_en1 = 1;
        cons_rand1 = 1;
        for (int i = 0; i < 10; i++) send_msg(mk(6, 5, i, i), "wrap_ack");
        wait_idle("wrap_drain");
        checks++;
        if (dlv1 != base1 + 10) begin
            errors++;
            $display("FAIL wrap_count: delivered=%0d expected 10", dlv1 - base1);
        end
        cons_rand1 = 0;
    endtask

    task automatic test_push_pop_full;
        msg_t got;
        msg_t m = mk(5, 0, 8'h20, 1);
        cons_en0 = 0;
        for (int i = 0; i < 5; i++) send_msg(mk(5, 0, 8'h10 + i, 0), "pp_fill_ack");
        @(negedge i_clk);
        got = {snd0_src, snd0_dst, snd0_dat, snd0_red};
        checks++;
        if (snd0_req !== 1'b1 || exp0.size() == 0 || got !== exp0[0]) begin
            errors++;
            $display("FAIL pp_head: req0=%b got %h expected %h", snd0_req, got, mk(5, 0, 8'h10, 0));
        end
        if (exp0.size() != 0) void'(exp0.pop_front());
        snd0_ack = 1'b1;
        @(negedge i_clk);
        snd0_ack = 1'b0;
        @(negedge i_clk);
        drive_msg(m);
        @(negedge i_clk);
        checks++;
        if (rcv0_ack !== 1'b0 || snd0_req !== 1'b1) begin
            errors++;
            $display("FAIL pp_refuse: ack=%b req0=%b expected ack=0 req0=1", rcv0_ack, snd0_req);
        end
        @(negedge i_clk);
        checks++;
        if (rcv0_ack !== 1'b1) begin
            errors++;
            $display("FAIL pp_accept: ack=%b expected 1 on following cycle", rcv0_ack);
        end else begin
            exp0.push_back(m);
        end
        rcv0_req = 1'b0;
        cons_en0 = 1;
        wait_idle("pp_drain");
    endtask

    task automatic test_reset_midflight;
        int rises = 0;
        cons_en0 = 0;
        for (int i = 0; i < 4; i++) send_msg(mk(7, 3, 8'h40 + i, 2), "mid_fill_ack");
        @(negedge i_clk);
        checks++;
        if (snd0_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_req0: req0=%b expected 1 before reset", snd0_req);
        end
        reset = 1'b1;
        @(negedge i_clk);
        checks++;
        if ({ready, rcv0_ack, snd0_req, snd1_req} !== 4'b0000 ||
            {snd0_src, snd0_dst, snd0_dat, snd0_red, snd1_src, snd1_dst, snd1_dat, snd1_red} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ready/ack/req0/req1=%b msg0=%h expected 0000 and 0",
                     {ready, rcv0_ack, snd0_req, snd1_req}, {snd0_src, snd0_dst, snd0_dat, snd0_red});
        end
        exp0.delete();
        reset = 1'b0;
        @(negedge i_clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready: ready=%b expected 1 after re-init", ready);
        end
        repeat (20) begin
            @(negedge i_clk);
            if (snd0_req || snd1_req) rises++;
        end
        checks++;
        if (rises != 0) begin
            errors++;
            $display("FAIL mid_stale: %0d request cycles seen, expected 0", rises);
        end
        cons_en0 = 1;
        cons_en1 = 1;
        send_msg(mk(8, 3, 8'hC3, 4), "mid_fresh0_ack");
        send_msg(mk(8, 6, 8'h3C, 4), "mid_fresh1_ack");
        wait_idle("mid_drain");
    endtask

    initial begin
        reset    = 1'b1;
        rcv0_src = '0;
        rcv0_dst = '0;
        rcv0_dat = '0;
        rcv0_red = '0;
        rcv0_req = 1'b0;
        test_reset();
        test_single_route();
        test_isolation();
        test_wrap();
        test_push_pop_full();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
